// File: rtl/alu_uart_ctrl_pkg.sv
// Shared definitions for the ALU sequencing front end: FSM encoding and ALU opcodes.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_uart_ctrl_pkg;

    localparam logic [2:0] ST_GET_A    = 3'd0;
    localparam logic [2:0] ST_GET_B    = 3'd1;
    localparam logic [2:0] ST_GET_OP   = 3'd2;
    localparam logic [2:0] ST_COMPUTE  = 3'd3;
    localparam logic [2:0] ST_SEND     = 3'd4;

    typedef enum logic [2:0] {
        GET_A   = ST_GET_A,
        GET_B   = ST_GET_B,
        GET_OP  = ST_GET_OP,
        COMPUTE = ST_COMPUTE,
        SEND    = ST_SEND
    } state_t;

    // Opcodes understood by the ALU; anything else yields a zero result there.
    localparam logic [5:0] OP_ADD = 6'b100000;
    localparam logic [5:0] OP_SUB = 6'b100010;
    localparam logic [5:0] OP_AND = 6'b100100;
    localparam logic [5:0] OP_OR  = 6'b100101;
    localparam logic [5:0] OP_XOR = 6'b100110;
    localparam logic [5:0] OP_NOR = 6'b100111;
    localparam logic [5:0] OP_SRA = 6'b000011;
    localparam logic [5:0] OP_SRL = 6'b000010;

endpackage

// File: rtl/alu_uart_ctrl.sv
// Collects A, B, opcode from an rx pulse stream, presents them to the ALU, returns the result on tx.
// Latency: result valid two edges after the opcode pulse is accepted (one full ALU settle cycle).
// Backpressure: tx is valid/ready; rx cannot be stalled, words arriving in COMPUTE/SEND are dropped and flagged.
module alu_uart_ctrl
    import alu_uart_ctrl_pkg::*;
#(
    parameter int NB_DATA = 8,
    parameter int NB_OP   = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_valid,
    output logic [NB_DATA-1:0] o_data_a,
    output logic [NB_DATA-1:0] o_data_b,
    output logic [NB_OP-1:0]   o_op,
    input  logic [NB_DATA-1:0] i_result,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic               o_tx_valid,
    input  logic               i_tx_ready,
    output logic               o_overrun,
    output logic               o_busy
);

    state_t state;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state      <= GET_A;
            o_data_a   <= '0;
            o_data_b   <= '0;
            o_op       <= '0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_overrun  <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            case (state)
                GET_A: begin
                    if (i_rx_valid) begin
                        o_data_a <= i_rx_data;
                        o_busy   <= 1'b1;
                        state    <= GET_B;
                    end
                end
                GET_B: begin
                    if (i_rx_valid) begin
                        o_data_b <= i_rx_data;
                        state    <= GET_OP;
                    end
                end
                GET_OP: begin
                    if (i_rx_valid) begin
                        o_op  <= i_rx_data[NB_OP-1:0];
                        state <= COMPUTE;
                    end
                end
                // o_op has been stable for a full cycle here, so i_result is settled.
                COMPUTE: begin
                    o_tx_data  <= i_result;
                    o_tx_valid <= 1'b1;
                    state      <= SEND;
                    if (i_rx_valid) begin
                        o_overrun <= 1'b1;
                    end
                end
                SEND: begin
                    if (i_rx_valid) begin
                        o_overrun <= 1'b1;
                    end
                    if (o_tx_valid && i_tx_ready) begin
                        o_tx_valid <= 1'b0;
                        o_busy     <= 1'b0;
                        state      <= GET_A;
                    end
                end
                default: begin
                    o_tx_valid <= 1'b0;
                    o_busy     <= 1'b0;
                    state      <= GET_A;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_uart_ctrl.sv
// Directed and randomized checks of the ALU sequencing front end against a behavioural ALU/frame model.
module tb_alu_uart_ctrl;
    import alu_uart_ctrl_pkg::*;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_rx_data;
    logic       i_rx_valid;
    logic [7:0] o_data_a;
    logic [7:0] o_data_b;
    logic [5:0] o_op;
    logic [7:0] i_result;
    logic [7:0] o_tx_data;
    logic       o_tx_valid;
    logic       i_tx_ready;
    logic       o_overrun;
    logic       o_busy;

    int tests  = 0;
    int failed = 0;

    alu_uart_ctrl #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_data_a   (o_data_a),
        .o_data_b   (o_data_b),
        .o_op       (o_op),
        .i_result   (i_result),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_overrun  (o_overrun),
        .o_busy     (o_busy)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        int sa;
        case (op)
            OP_ADD:  return 8'((int'(a) + int'(b)) % 256);
            OP_SUB:  return 8'((int'(a) - int'(b) + 256) % 256);
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SRL:  return (b > 7) ? 8'h00 : 8'(int'(a) / (1 << b));
            OP_SRA: begin
                sa = (a[7]) ? int'(a) - 256 : int'(a);
                for (int k = 0; k < int'(b) && k < 8; k++) sa = (sa < 0) ? -((-sa + 1) / 2) : sa / 2;
                return 8'(sa & 255);
            end
            default: return 8'h00;
        endcase
    endfunction

    // Combinational ALU attached to the DUT's registered operand outputs.
    always_comb i_result = alu_model(o_data_a, o_data_b, o_op);

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            i_rx_data = 8'($urandom_range(255));
            tick();
        end
    endtask

    task automatic pulse(input logic [7:0] w);
        i_rx_data  = w;
        i_rx_valid = 1'b1;
        tick();
        i_rx_valid = 1'b0;
        i_rx_data  = 8'($urandom_range(255));
    endtask

    // One full frame; ready stays low for `hold` cycles after the result appears.
    task automatic run_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opw,
                             input int gap, input int hold, input logic [7:0] exp_res);
        pulse(a);
        idle(gap);
        pulse(b);
        idle(gap);
        i_tx_ready = (hold == 0);
        pulse(opw);
        check("op_latched", {2'b00, o_op}, {2'b00, opw[5:0]});
        check("valid_low_in_compute", {7'd0, o_tx_valid}, 8'd0);
        check("busy_in_compute", {7'd0, o_busy}, 8'd1);
        tick();
        check("valid_rise", {7'd0, o_tx_valid}, 8'd1);
        check("tx_data", o_tx_data, exp_res);
        for (int i = 0; i < hold; i++) begin
            tick();
            check("valid_held", {7'd0, o_tx_valid}, 8'd1);
            check("data_stable", o_tx_data, exp_res);
        end
        i_tx_ready = 1'b1;
        tick();
        check("valid_fall", {7'd0, o_tx_valid}, 8'd0);
        check("idle_after_send", {7'd0, o_busy}, 8'd0);
    endtask

    logic [5:0] valid_ops [8];

    initial begin
        logic [7:0] a, b, opw;
        logic [5:0] op6;

        valid_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_NOR, OP_SRA, OP_SRL};
        i_rst      = 1'b1;
        i_rx_data  = 8'h00;
        i_rx_valid = 1'b0;
        i_tx_ready = 1'b1;
        tick();
        tick();
        check("rst_a", o_data_a, 8'h00);
        check("rst_b", o_data_b, 8'h00);
        check("rst_op", {2'b00, o_op}, 8'h00);
        check("rst_tx_data", o_tx_data, 8'h00);
        check("rst_flags", {5'd0, o_tx_valid, o_overrun, o_busy}, 8'h00);
        i_rst = 1'b0;
        tick();

        // Basic ADD, back-to-back words
        run_frame(8'h05, 8'h03, 8'h20, 0, 0, 8'h08);
        check("add_op", {2'b00, o_op}, 8'h20);

        // Opcode upper bits discarded: 0xE2 -> SUB
        run_frame(8'h10, 8'h01, 8'hE2, 1, 0, 8'h0F);
        check("trunc_op", {2'b00, o_op}, 8'h22);

        // SRA with 5 cycles of backpressure
        run_frame(8'h80, 8'h02, 8'h03, 1, 5, 8'hE0);
        // Next A accepted the cycle right after the handshake
        pulse(8'h42);
        check("a_after_handshake", o_data_a, 8'h42);
        check("busy_after_a", {7'd0, o_busy}, 8'd1);
        pulse(8'h01);
        i_tx_ready = 1'b0;
        pulse({2'b00, OP_ADD});
        tick();
        check("overrun_clear_before", {7'd0, o_overrun}, 8'd0);
        pulse(8'h99);
        check("overrun_in_send", {7'd0, o_overrun}, 8'd1);
        check("send_data_kept", o_tx_data, 8'h43);
        check("send_valid_kept", {7'd0, o_tx_valid}, 8'd1);
        i_tx_ready = 1'b1;
        pulse(8'h77);
        check("handshake_with_rx", {6'd0, o_tx_valid, o_busy}, 8'd0);
        check("dropped_not_latched", o_data_a, 8'h42);
        run_frame(8'h0F, 8'hF0, {2'b00, OP_OR}, 2, 1, 8'hFF);
        check("overrun_sticky", {7'd0, o_overrun}, 8'd1);

        // Asynchronous reset with A and B already received
        pulse(8'h33);
        pulse(8'h44);
        #2;
        i_rst = 1'b1;
        #1;
        check("mid_rst_a", o_data_a, 8'h00);
        check("mid_rst_b", o_data_b, 8'h00);
        check("mid_rst_flags", {5'd0, o_tx_valid, o_overrun, o_busy}, 8'h00);
        tick();
        i_rst = 1'b0;
        tick();
        pulse(8'h07);
        check("post_rst_no_result", {7'd0, o_tx_valid}, 8'd0);
        check("post_rst_a", o_data_a, 8'h07);
        pulse(8'h06);
        i_tx_ready = 1'b1;
        pulse({2'b00, OP_XOR});
        tick();
        check("post_rst_result", o_tx_data, 8'h01);
        tick();
        check("post_rst_done", {6'd0, o_tx_valid, o_busy}, 8'd0);

        // Randomized frames, legal and illegal opcodes
        for (int f = 0; f < 1000; f++) begin
            a = 8'($urandom_range(255));
            b = ($urandom_range(3) == 0) ? 8'($urandom_range(9)) : 8'($urandom_range(255));
            op6 = ($urandom_range(3) == 0) ? 6'($urandom_range(63)) : valid_ops[$urandom_range(7)];
            opw = {2'($urandom_range(3)), op6};
            run_frame(a, b, opw, $urandom_range(3), $urandom_range(3), alu_model(a, b, op6));
        end
        check("illegal_op_zero", alu_model(8'h12, 8'h34, 6'h3F), 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/alu_uart_ctrl.md
# alu_uart_ctrl

Sequencing front end for the ALU. It takes a byte-wide receive stream of one-cycle pulses, collects operand A, operand B and the opcode, and presents them as registered values to the ALU. It then captures the ALU result and returns it on a transmit stream with a valid/ready handshake. It sits between the serial receiver/transmitter pair and the ALU in the board top level.

## Interface
Parameters:
- NB_DATA, 8: width of operands, result, and both stream words.
- NB_OP, 6: ALU opcode width; taken from the low NB_OP bits of the third received word (requires NB_OP ≤ NB_DATA).

Ports:
- i_clk  in  1  single system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_rx_data  in  NB_DATA  received word, valid only while i_rx_valid is high.
- i_rx_valid  in  1  one-cycle pulse per received word; no backpressure toward the receiver.
- o_data_a  out  NB_DATA  registered operand A to the ALU.
- o_data_b  out  NB_DATA  registered operand B to the ALU.
- o_op  out  NB_OP  registered opcode to the ALU.
- i_result  in  NB_DATA  combinational ALU result.
- o_tx_data  out  NB_DATA  result word toward the transmitter.
- o_tx_valid  out  1  result word available.
- i_tx_ready  in  1  transmitter accepts the word.
- o_overrun  out  1  sticky flag: an rx word arrived while the block could not accept it.
- o_busy  out  1  high in every state except GET_A.

## Operation
- FSM states, in order: GET_A, GET_B, GET_OP, COMPUTE, SEND.
- GET_A, on i_rx_valid: o_data_a ← i_rx_data, then go to GET_B.
- GET_B, on i_rx_valid: o_data_b ← i_rx_data, then go to GET_OP.
- GET_OP, on i_rx_valid: o_op ← i_rx_data[NB_OP-1:0] with upper bits discarded, then go to COMPUTE.
- COMPUTE is exactly one cycle, unconditional.
  - o_tx_data ← i_result; o_tx_valid ← 1; go to SEND.
- SEND:
  - o_tx_valid held high; o_tx_data stable.
  - When o_tx_valid && i_tx_ready at a clock edge: o_tx_valid ← 0, go to GET_A.
- An i_rx_valid pulse in COMPUTE or SEND is dropped and sets o_overrun.
  - This includes the cycle in which the handshake completes.
- o_data_a, o_data_b and o_op retain their last values between frames. They are not cleared on return to GET_A.
- Opcodes are not validated here. The ALU handles unknown codes.
- Reset values:
  - State = GET_A.
  - o_data_a, o_data_b, o_op, o_tx_data = 0.
  - o_tx_valid = 0, o_overrun = 0, o_busy = 0.
- Reset mid-frame discards any partial frame and any pending result. No result is emitted.

## Timing
- All outputs are registered; there is no combinational path from any input to any output.
- Opcode pulse accepted at edge n:
  - o_op is valid after edge n.
  - i_result is sampled at edge n+1, giving the ALU one full cycle to settle.
  - o_tx_valid rises after edge n+1.
- Minimum frame period: 3 rx cycles + COMPUTE + 1 SEND cycle (when ready is high).
  - The next A word is accepted no earlier than the cycle after the handshake.
- o_tx_data does not change while o_tx_valid is high.
- o_overrun is cleared only by i_rst.

## Structure
- Shared package / include file holds:
  - the state encoding localparams (3-bit: GET_A=0, GET_B=1, GET_OP=2, COMPUTE=3, SEND=4);
  - the opcode constants already used by the ALU, so benches and the top level share them.
- No sub-module inside this block. The board top instantiates this block alongside the ALU and the serial RX/TX blocks.

## Test plan
- Basic ADD frame:
  - Stimulus: rx 0x05, 0x03, 0x20; ready held high; ALU instantiated.
  - Required: o_op=6'b100000; o_tx_data=0x08, valid for 1 cycle, 2 cycles after the op pulse.
- Opcode truncation:
  - Stimulus: op word 0xE2 with A=0x10, B=0x01.
  - Required: o_op=6'b100010; result 0x0F.
- Backpressure:
  - Stimulus: SRA frame A=0x80, B=0x02, op=0x03; ready low for 5 cycles.
  - Required: o_tx_data=0xE0 and valid held stable for all 5 cycles; return to GET_A the cycle after ready rises.
- Overrun:
  - Stimulus: rx pulse during SEND, and a second pulse on the exact handshake cycle.
  - Required: both words dropped; o_overrun=1 and stays set; next frame still processed correctly.
- Reset mid-frame:
  - Stimulus: assert i_rst after A and B are received.
  - Required: all outputs 0 and state GET_A immediately (asynchronous); a following full frame produces the correct result.
- Randomized:
  - Stimulus: 1000 frames with random A, B, op drawn from the 8 valid codes plus illegal codes, random rx gaps, random ready.
  - Required: every o_tx_data matches the scoreboard model; illegal op gives 0x00.
